// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Holds request size codes, FSM state type, byte-lane enable constants and
// small helpers that map a request onto memory lanes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see load_store_unit.sv).
package lsu_pkg;

    // Request size encoding; code 3 behaves as a word access.
    localparam logic [1:0] SIZE_BYTE     = 2'd0;
    localparam logic [1:0] SIZE_HALF     = 2'd1;
    localparam logic [1:0] SIZE_WORD     = 2'd2;
    localparam logic [1:0] SIZE_WORD_ALT = 2'd3;

    // Byte-lane enable patterns (lane k = bits [8k+7:8k]).
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // Request attributes still needed after the memory access completes.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       is_signed;
        logic [1:0] addr_lo;
    } req_info_t;

    // Lane enables for a given size and low address bits.
    function automatic logic [3:0] lane_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: lane_enable = BE_BYTE0 << addr_lo;
            SIZE_HALF: lane_enable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            default:   lane_enable = BE_WORD;
        endcase
    endfunction

    // Replicate right-justified store data across every lane it may land in.
    function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                              input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: lane_data = {4{wdata[7:0]}};
            SIZE_HALF: lane_data = {2{wdata[15:0]}};
            default:   lane_data = wdata;
        endcase
    endfunction

    // True when a half/word access is not naturally aligned.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr_lo[0];
            default:   misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: picks the addressed lane(s) out of a read word and
// sign- or zero-extends them to 32 bits. Purely combinational.
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed lane(s) and extend to a full word.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        result    = rdata;
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: result = {{24{is_signed & byte_lane[7]}}, byte_lane};
            SIZE_HALF: result = {{16{is_signed & half_lane[15]}}, half_lane};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store front end.
// IDLE accepts a request, ACCESS drives the memory strobe until ack or
// timeout, RESP emits a one-cycle completion pulse.
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1; req_ready is high only in IDLE. The memory side holds mem_en
// and all mem_* fields stable until mem_ack=1 is sampled.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests
// skip the memory access and complete with rsp_err=1.
// The FSM state is exported on the state port for observation.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output lsu_state_t  state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    req_info_t        info;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      load_result;

    load_extract u_load_extract (
        .rdata     (mem_rdata),
        .addr_lo   (info.addr_lo),
        .size      (info.size),
        .is_signed (info.is_signed),
        .result    (load_result)
    );

    // Ready only while idle, so at most one request is ever in flight.
    assign req_ready = (state == ST_IDLE);

    // Main FSM with registered memory and response outputs. The counter holds
    // the number of ACCESS cycles spent so far, including the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            info      <= '0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= BE_NONE;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        info.we        <= req_we;
                        info.size      <= req_size;
                        info.is_signed <= req_signed;
                        info.addr_lo   <= req_addr[1:0];
                        rsp_rdata      <= 32'h0;
                        rsp_err        <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else
`endif
                        begin
                            state     <= ST_ACCESS;
                            cnt       <= CNT_W'(1);
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= lane_enable(req_size, req_addr[1:0]);
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= lane_data(req_size, req_wdata);
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack takes priority, so an ack in the final allowed cycle succeeds.
                    if (mem_ack) begin
                        state     <= ST_RESP;
                        cnt       <= '0;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= info.we ? 32'h0 : load_result;
                    end else if (cnt == CNT_LIMIT) begin
                        state     <= ST_RESP;
                        cnt       <= '0;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a short
// timeout (4 cycles). Inputs change and outputs are sampled 1 time unit
// after each rising clock edge.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    lsu_state_t  dut_state;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .state      (dut_state)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in the first ACCESS cycle.
    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    // Ack immediately in the current ACCESS cycle and land in RESP.
    task automatic ack_now(input logic [31:0] rdata);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_state", 32'(dut_state), 32'(ST_IDLE));
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Signed byte load at 0x103, ack on second ACCESS cycle
        send(1'b0, SIZE_BYTE, 1'b1, 32'h0000_0103, 32'h0);
        chk("bl_mem_en", 32'(mem_en), 32'd1);
        chk("bl_ready_low", 32'(req_ready), 32'd0);
        chk("bl_mem_addr", mem_addr, 32'h0000_0100);
        chk("bl_mem_be", 32'(mem_be), 32'h8);
        chk("bl_mem_we", 32'(mem_we), 32'd0);
        mem_rdata = 32'h80FF_1234;
        tick();
        chk("bl_hold_en", 32'(mem_en), 32'd1);
        chk("bl_hold_addr", mem_addr, 32'h0000_0100);
        chk("bl_no_rsp", 32'(rsp_valid), 32'd0);
        ack_now(32'h80FF_1234);
        chk("bl_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bl_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
        chk("bl_rsp_err", 32'(rsp_err), 32'd0);
        chk("bl_mem_en_off", 32'(mem_en), 32'd0);
        chk("bl_resp_ready", 32'(req_ready), 32'd0);
        tick();
        chk("bl_pulse_end", 32'(rsp_valid), 32'd0);
        chk("bl_back_idle", 32'(req_ready), 32'd1);

        // Half store at 0x202, minimum latency
        send(1'b1, SIZE_HALF, 1'b0, 32'h0000_0202, 32'h0000_BEEF);
        chk("hs_mem_be", 32'(mem_be), 32'hC);
        chk("hs_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("hs_mem_addr", mem_addr, 32'h0000_0200);
        chk("hs_mem_we", 32'(mem_we), 32'd1);
        ack_now(32'h1111_2222);
        chk("hs_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hs_rsp_rdata", rsp_rdata, 32'h0);
        chk("hs_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // Byte store at 0x001
        send(1'b1, SIZE_BYTE, 1'b0, 32'h0000_0001, 32'h1234_56A5);
        chk("bs_mem_be", 32'(mem_be), 32'h2);
        chk("bs_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        ack_now(32'h0);
        chk("bs_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();

        // Unsigned half load, upper half
        send(1'b0, SIZE_HALF, 1'b0, 32'h0000_0012, 32'h0);
        chk("hlu_mem_be", 32'(mem_be), 32'hC);
        ack_now(32'h9ABC_5678);
        chk("hlu_rsp_rdata", rsp_rdata, 32'h0000_9ABC);
        tick();

        // Signed half load, lower half
        send(1'b0, SIZE_HALF, 1'b1, 32'h0000_0010, 32'h0);
        chk("hls_mem_be", 32'(mem_be), 32'h3);
        ack_now(32'h1234_F00D);
        chk("hls_rsp_rdata", rsp_rdata, 32'hFFFF_F00D);
        tick();

        // Unsigned byte load, lane 2 with top bit set
        send(1'b0, SIZE_BYTE, 1'b0, 32'h0000_0002, 32'h0);
        ack_now(32'h11A2_B3C4);
        chk("blu_rsp_rdata", rsp_rdata, 32'h0000_00A2);
        tick();

        // Word load at misaligned 0x101
        send(1'b0, SIZE_WORD, 1'b0, 32'h0000_0101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("wm_mem_en", 32'(mem_en), 32'd0);
        chk("wm_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wm_rsp_err", 32'(rsp_err), 32'd1);
        chk("wm_rsp_rdata", rsp_rdata, 32'h0);
`else
        chk("wm_mem_en", 32'(mem_en), 32'd1);
        chk("wm_mem_addr", mem_addr, 32'h0000_0100);
        chk("wm_mem_be", 32'(mem_be), 32'hF);
        ack_now(32'hCAFE_F00D);
        chk("wm_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        chk("wm_rsp_err", 32'(rsp_err), 32'd0);
`endif
        tick();
        chk("wm_idle", 32'(dut_state), 32'(ST_IDLE));

        // Timeout: no ack, mem_en high for exactly 4 cycles
        send(1'b0, SIZE_WORD, 1'b0, 32'h0000_0400, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_mem_en_%0d", i), 32'(mem_en), 32'd1);
            chk($sformatf("to_no_rsp_%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        chk("to_mem_en_off", 32'(mem_en), 32'd0);
        tick();

        // Ack in the final allowed cycle counts as success
        send(1'b0, SIZE_WORD, 1'b0, 32'h0000_0300, 32'h0);
        repeat (3) tick();
        chk("tb_still_access", 32'(mem_en), 32'd1);
        ack_now(32'hDEAD_BEEF);
        chk("tb_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tb_rsp_err", 32'(rsp_err), 32'd0);
        chk("tb_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // Ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("ign_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ign_state", 32'(dut_state), 32'(ST_IDLE));

        // Reset pulse in the middle of an access
        send(1'b0, SIZE_WORD, 1'b0, 32'h0000_0500, 32'h0);
        chk("ra_mem_en", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_mem_en_off", 32'(mem_en), 32'd0);
        chk("ra_state", 32'(dut_state), 32'(ST_IDLE));
        chk("ra_mem_addr", mem_addr, 32'h0);
        #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        tick();
        chk("ra_no_rsp_0", 32'(rsp_valid), 32'd0);
        tick();
        chk("ra_no_rsp_1", 32'(rsp_valid), 32'd0);
        mem_ack = 1'b0;
        send(1'b0, SIZE_BYTE, 1'b0, 32'h0000_0001, 32'h0);
        chk("ra_new_mem_en", 32'(mem_en), 32'd1);
        ack_now(32'h0000_7F00);
        chk("ra_new_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ra_new_rsp_rdata", rsp_rdata, 32'h0000_007F);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
